// File: rtl/uart_rx_fifo_writer.sv
// 8N1 UART receiver that pushes each good byte into a downstream FIFO.
// A stop-bit error or a full FIFO at the stop sample produces a one-cycle error pulse instead.
module uart_rx_fifo_writer #(
   parameter int CLKS_PER_BIT = 5208
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       serial_in,
   input  logic       fifo_full,
   output logic       fifo_write,
   output logic [7:0] fifo_data_in,
   output logic       rx_busy,
   output logic       frame_err,
   output logic       overrun_err
);

   localparam logic [15:0] HALF_CNT = 16'((CLKS_PER_BIT - 1) / 2);
   localparam logic [15:0] FULL_CNT = 16'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

   state_t      state_q;
   logic        sync1_q, rx_s_q;
   logic [15:0] clock_count_q;
   logic [2:0]  bit_index_q;
   logic [7:0]  shift_q;
   logic [7:0]  data_q;
   logic        fifo_write_q, frame_err_q, overrun_err_q, rx_busy_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= IDLE;
         sync1_q       <= 1'b1;
         rx_s_q        <= 1'b1;
         clock_count_q <= '0;
         bit_index_q   <= '0;
         shift_q       <= '0;
         data_q        <= '0;
         fifo_write_q  <= 1'b0;
         frame_err_q   <= 1'b0;
         overrun_err_q <= 1'b0;
         rx_busy_q     <= 1'b0;
      end else begin
         sync1_q       <= serial_in;
         rx_s_q        <= sync1_q;
         fifo_write_q  <= 1'b0;
         frame_err_q   <= 1'b0;
         overrun_err_q <= 1'b0;
         case (state_q)
            IDLE: begin
               clock_count_q <= '0;
               bit_index_q   <= '0;
               if (!rx_s_q) begin
                  state_q   <= START;
                  rx_busy_q <= 1'b1;
               end
            end
            START: begin
               if (clock_count_q == HALF_CNT) begin
                  clock_count_q <= '0;
                  if (!rx_s_q) begin
                     state_q <= DATA;
                  end else begin
                     state_q   <= IDLE;
                     rx_busy_q <= 1'b0;
                  end
               end else begin
                  clock_count_q <= clock_count_q + 16'd1;
               end
            end
            DATA: begin
               if (clock_count_q == FULL_CNT) begin
                  clock_count_q        <= '0;
                  shift_q[bit_index_q] <= rx_s_q;
                  if (bit_index_q == 3'd7) begin
                     bit_index_q <= '0;
                     state_q     <= STOP;
                  end else begin
                     bit_index_q <= bit_index_q + 3'd1;
                  end
               end else begin
                  clock_count_q <= clock_count_q + 16'd1;
               end
            end
            STOP: begin
               if (clock_count_q == FULL_CNT) begin
                  clock_count_q <= '0;
                  // fifo_full only matters in this one sample cycle
                  if (rx_s_q) begin
                     state_q   <= IDLE;
                     rx_busy_q <= 1'b0;
                     if (!fifo_full) begin
                        fifo_write_q <= 1'b1;
                        data_q       <= shift_q;
                     end else begin
                        overrun_err_q <= 1'b1;
                     end
                  end else begin
                     frame_err_q <= 1'b1;
                     state_q     <= BREAK;
                  end
               end else begin
                  clock_count_q <= clock_count_q + 16'd1;
               end
            end
            BREAK: begin
               if (rx_s_q) begin
                  state_q   <= IDLE;
                  rx_busy_q <= 1'b0;
               end
            end
            default: begin
               state_q   <= IDLE;
               rx_busy_q <= 1'b0;
            end
         endcase
      end
   end

   assign fifo_write   = fifo_write_q;
   assign fifo_data_in = data_q;
   assign rx_busy      = rx_busy_q;
   assign frame_err    = frame_err_q;
   assign overrun_err  = overrun_err_q;

endmodule

// File: tb/tb_uart_rx_fifo_writer.sv
// Directed + randomized frames checked against a frame-level outcome model.
module tb_uart_rx_fifo_writer;

   localparam int CPB = 8;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       serial_in = 1'b1;
   logic       fifo_full = 1'b0;
   logic       fifo_write;
   logic [7:0] fifo_data_in;
   logic       rx_busy;
   logic       frame_err;
   logic       overrun_err;

   int checks = 0;
   int errors = 0;

   // observed events (monitor) and expected events (model)
   int obs_wr[$];
   int exp_wr[$];
   int obs_fe = 0, obs_ov = 0, exp_fe = 0, exp_ov = 0;
   int excl_viol = 0;
   int last_byte = 0;

   uart_rx_fifo_writer #(.CLKS_PER_BIT(CPB)) dut (
      .clk(clk), .rst(rst), .serial_in(serial_in), .fifo_full(fifo_full),
      .fifo_write(fifo_write), .fifo_data_in(fifo_data_in), .rx_busy(rx_busy),
      .frame_err(frame_err), .overrun_err(overrun_err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (fifo_write) obs_wr.push_back(int'(fifo_data_in));
      if (frame_err) obs_fe++;
      if (overrun_err) obs_ov++;
      if (int'(fifo_write) + int'(frame_err) + int'(overrun_err) > 1) excl_viol++;
   end

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // One 8N1 frame; fifo_full wanders during data bits and settles before the stop bit.
   task automatic send_frame(input logic [7:0] b, input logic stopb, input logic ff,
                             input int low_hold);
      serial_in = 1'b0;
      idle(CPB);
      for (int i = 0; i < 8; i++) begin
         serial_in = b[i];
         fifo_full = 1'($urandom_range(0, 1));
         idle(CPB);
      end
      fifo_full = ff;
      serial_in = stopb;
      idle(CPB);
      if (!stopb) idle(low_hold);
      serial_in = 1'b1;
      if (!stopb) exp_fe++;
      else if (ff) exp_ov++;
      else begin
         exp_wr.push_back(int'(b));
         last_byte = int'(b);
      end
   endtask

   task automatic check_events(input string tag);
      idle(4);
      chk({tag, "_nwr"}, obs_wr.size(), exp_wr.size());
      for (int i = 0; i < exp_wr.size() && i < obs_wr.size(); i++)
         chk({tag, "_data"}, obs_wr[i], exp_wr[i]);
      chk({tag, "_ferr"}, obs_fe, exp_fe);
      chk({tag, "_ovr"}, obs_ov, exp_ov);
      chk({tag, "_busy"}, int'(rx_busy), 0);
      chk({tag, "_hold"}, int'(fifo_data_in), last_byte);
      obs_wr.delete(); exp_wr.delete();
      obs_fe = 0; obs_ov = 0; exp_fe = 0; exp_ov = 0;
      fifo_full = 1'b0;
   endtask

   initial begin
      idle(3);
      chk("rst_write", int'(fifo_write), 0);
      chk("rst_data", int'(fifo_data_in), 0);
      chk("rst_busy", int'(rx_busy), 0);
      chk("rst_ferr", int'(frame_err), 0);
      chk("rst_ovr", int'(overrun_err), 0);
      rst = 1'b0;
      idle(5);

      send_frame(8'hA5, 1'b1, 1'b0, 0);
      check_events("a5");

      send_frame(8'h00, 1'b1, 1'b0, 0);
      send_frame(8'hFF, 1'b1, 1'b0, 0);
      check_events("b2b");

      serial_in = 1'b0;
      idle(2);
      serial_in = 1'b1;
      idle(2);
      chk("glitch_busy_mid", int'(rx_busy), 1);
      idle(16);
      check_events("glitch");

      // stop bit low, line held low 40 clk in total from the stop bit onward
      fork
         send_frame(8'h3C, 1'b0, 1'b0, 40 - CPB);
         begin
            idle(9 * CPB + 30);
            chk("brk_busy_low", int'(rx_busy), 1);
         end
      join
      check_events("break");

      send_frame(8'h5A, 1'b1, 1'b1, 0);
      check_events("ovr");
      send_frame(8'h12, 1'b1, 1'b0, 0);
      check_events("after_ovr");

      // reset in the middle of data bit 4 of 0x81
      serial_in = 1'b0;
      idle(CPB);
      for (int i = 0; i < 4; i++) begin
         serial_in = i[0] ? 1'b0 : (i == 0);
         idle(CPB);
      end
      serial_in = 1'b0;
      idle(3);
      rst = 1'b1;
      serial_in = 1'b1;
      idle(2);
      chk("mid_rst_busy", int'(rx_busy), 0);
      chk("mid_rst_data", int'(fifo_data_in), 0);
      last_byte = 0;
      rst = 1'b0;
      idle(10);
      send_frame(8'h42, 1'b1, 1'b0, 0);
      check_events("rst_42");

      for (int n = 0; n < 24; n++) begin
         logic [7:0] b;
         logic sb, ff;
         b  = 8'($urandom);
         sb = ($urandom_range(0, 5) != 0);
         ff = ($urandom_range(0, 3) == 0);
         send_frame(b, sb, ff, int'($urandom_range(0, 30)));
         idle(int'($urandom_range(0, 10)));
         if (n % 4 == 3) check_events("rand");
      end
      check_events("rand_end");

      chk("exclusive", excl_viol, 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_rx_fifo_writer.md
UART_RX_FIFO_WRITER -- requirements
Module: uart_rx_fifo_writer

Interface
REQ-001 Parameter CLKS_PER_BIT, default 50_000_000/9600 (5208): clk cycles per UART bit; legal range 4..65535.
REQ-002 clk  input  1  system clock; all logic on its rising edge.
REQ-003 rst  input  1  reset; asynchronous, active-high.
REQ-004 serial_in  input  1  UART line, asynchronous to clk, idles high.
REQ-005 fifo_full  input  1  downstream FIFO cannot accept a write this cycle.
REQ-006 fifo_write  output  1  one-cycle write strobe to the FIFO.
REQ-007 fifo_data_in  output  8  received byte; valid whenever fifo_write=1.
REQ-008 rx_busy  output  1  high while a frame is being received.
REQ-009 frame_err  output  1  one-cycle pulse: stop bit sampled low.
REQ-010 overrun_err  output  1  one-cycle pulse: good byte dropped because fifo_full=1.

Function
REQ-011 Frame format SHALL be 8N1: one start bit (0), 8 data bits LSB first, one stop bit (1).
REQ-012 serial_in SHALL pass through a 2-flop synchronizer (reset value 1); the FSM SHALL use only the synchronized value rx_s.
REQ-013 FSM states SHALL be IDLE, START, DATA, STOP, BREAK; a 16-bit clock_count and a 3-bit bit_index SHALL time the bits.
REQ-014 IDLE: clock_count=0, bit_index=0; on rx_s=0 go to START.
REQ-015 START: count until clock_count=(CLKS_PER_BIT-1)/2 (integer division); then rx_s=0 -> clear count, go to DATA; rx_s=1 -> false start, go to IDLE with no output pulse.
REQ-016 DATA: count until clock_count=CLKS_PER_BIT-1; then clear count and shift rx_s into data bit bit_index; after bit 7, clear bit_index and go to STOP, else increment bit_index.
REQ-017 STOP: count until clock_count=CLKS_PER_BIT-1, then sample rx_s.
REQ-018 Stop sample 1 and fifo_full=0: fifo_write=1 for exactly one cycle with fifo_data_in=byte; go to IDLE.
REQ-019 Stop sample 1 and fifo_full=1: no write; overrun_err=1 for one cycle; byte discarded; go to IDLE.
REQ-020 Stop sample 0: no write; frame_err=1 for one cycle; go to BREAK.
REQ-021 BREAK: remain until rx_s=1, then go to IDLE (a held-low line SHALL produce one frame_err only).
REQ-022 fifo_full SHALL be evaluated only in the stop-sample cycle; it has no effect elsewhere.
REQ-023 fifo_write, frame_err and overrun_err SHALL be mutually exclusive and default to 0 in every other cycle.
REQ-024 fifo_data_in SHALL hold its last value between writes.
REQ-025 rx_busy SHALL be 1 in START, DATA, STOP and BREAK, 0 in IDLE (registered, follows state).
REQ-026 Sampling points SHALL be mid-bit: start bit at half-bit, each later bit exactly CLKS_PER_BIT cycles apart.

Reset
REQ-027 On rst: state=IDLE, clock_count=0, bit_index=0, shift register=0, synchronizer flops=1, fifo_data_in=0, fifo_write=0, frame_err=0, overrun_err=0, rx_busy=0.
REQ-028 rst asserted mid-frame SHALL abort the frame with no write or error pulse; after release the block SHALL wait in IDLE for the next falling edge.

Verification (CLKS_PER_BIT=8)
REQ-029 Send 0xA5 at 8 clk/bit, fifo_full=0 -> single fifo_write pulse, fifo_data_in=0xA5, no error pulses, rx_busy back to 0.
REQ-030 Send 0x00 then 0xFF back-to-back -> two fifo_write pulses with 0x00 then 0xFF.
REQ-031 Low glitch of 2 clk on idle line -> no fifo_write, no errors, state returns to IDLE.
REQ-032 Send 0x3C with stop bit forced 0, line held low 40 clk then released -> one frame_err pulse, no write, rx_busy high until line high.
REQ-033 Send 0x5A with fifo_full=1 at stop sample -> one overrun_err pulse, no fifo_write; next byte 0x12 with fifo_full=0 -> written as 0x12.
REQ-034 Assert rst during data bit 4 of 0x81, then send 0x42 -> no output for 0x81; 0x42 written once.
